// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first over WIDTH cycles, then pulses done.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] areg, breg, rreg;
    logic             bflop;
    logic [CW-1:0]    cnt;
    logic             dbit, bout;
    logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of areg/breg, so keep them for the overflow test.
    logic             amsb, bmsb;
`endif

    assign dbit = areg[0] ^ breg[0] ^ bflop;
    assign bout = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & bflop);
    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            rreg   <= '0;
            bflop  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                areg  <= a;
                breg  <= b;
                bflop <= 1'b0;
                cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                amsb  <= a[WIDTH-1];
                bmsb  <= b[WIDTH-1];
`endif
            end else if (state == SHIFT) begin
                areg  <= {1'b0, areg[WIDTH-1:1]};
                breg  <= {1'b0, breg[WIDTH-1:1]};
                rreg  <= {dbit, rreg[WIDTH-1:1]};
                bflop <= bout;
                cnt   <= cnt + 1'b1;
                // The final bit is merged in directly so the outputs update on the DONE-entry edge.
                if (last) begin
                    diff   <= {dbit, rreg[WIDTH-1:1]};
                    borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf    <= (amsb != bmsb) && (dbit != amsb);
`endif
                end
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new subtraction, sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while bits are being processed (SHIFT).
REQ-008 SHALL have port: done  output  1  single-cycle pulse marking the result valid.
REQ-009 SHALL have port: diff  output  WIDTH  registered result a - b mod 2^WIDTH.
REQ-010 SHALL have port: borrow  output  1  registered final borrow; 1 iff a < b unsigned.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL load a and b into internal shift registers, clear the borrow flop and bit counter, then go to SHIFT.
REQ-013 IDLE with start=0 SHALL remain in IDLE, with no internal state change.
REQ-014 Each SHIFT cycle SHALL process the LSB: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
REQ-015 Each SHIFT cycle SHALL shift both operand registers right by one.
REQ-016 Each SHIFT cycle SHALL shift d into the MSB of the result shift register.
REQ-017 Each SHIFT cycle SHALL store bout in the borrow flop and increment the counter.
REQ-018 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE, loading diff and borrow from the result register and borrow flop on that same edge.
REQ-019 done SHALL be high for exactly one cycle (state DONE); DONE SHALL always return to IDLE on the next edge.
REQ-020 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the start-accepting edge (WIDTH=8: 8 cycles).
REQ-021 busy SHALL equal 1 only in SHIFT.
REQ-022 start SHALL be ignored in SHIFT and DONE; it is not queued.
REQ-023 Back-to-back operation: start high in the cycle after done SHALL be accepted (IDLE reached).
REQ-024 diff and borrow SHALL hold their last value between completions and change only on entry to DONE.
REQ-025 Changes on a/b after acceptance SHALL not affect the running operation.
REQ-026 The counter SHALL be sized to hold WIDTH without wrap.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE.
REQ-028 rst=1 SHALL asynchronously clear counter, operand, result and borrow registers.
REQ-029 rst=1 SHALL asynchronously drive busy=0, done=0, diff=0, borrow=0 (and ovf=0 when present).
REQ-030 Reset mid-operation SHALL abandon the operation with no done pulse; the block SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-031 Macro SERIAL_SUBTRACTOR_OVF_EN defined: SHALL add output port ovf (1 bit, after borrow) = signed two's-complement overflow, (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-032 With the macro, ovf SHALL be registered alongside diff on entry to DONE and held likewise.
REQ-033 Macro undefined: port ovf and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=8)
REQ-034 a=0x35, b=0x12, start 1 cycle -> busy 8 cycles, done pulse 8 cycles after accept, diff=0x23, borrow=0.
REQ-035 a=0x12, b=0x35 -> diff=0xDD, borrow=1; a=0x00, b=0x01 -> diff=0xFF, borrow=1.
REQ-036 With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-037 Start held high across whole operation with a/b changing mid-run -> single result from first-captured operands; second start accepted only from IDLE.
REQ-038 rst pulse during 4th SHIFT cycle -> immediate busy=0, diff=0, borrow=0, no done; new start afterwards completes correctly.
REQ-039 start asserted in cycle after done with a=0xFF, b=0xFF -> accepted, diff=0x00, borrow=0 after 8 cycles.
